// File: rtl/graph_pkg.sv
// ============================================================================
//  Module      : graph_pkg
//  Description : Shared wavefront_router types and graph index helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package graph_pkg;

   typedef enum logic [1:0] {
      WF_IDLE   = 2'd0,
      WF_SEARCH = 2'd1,
      WF_FINISH = 2'd2
   } wf_state_t;

   function automatic int node_width(input int nodes);
      return (nodes < 2) ? 1 : $clog2(nodes);
   endfunction

   function automatic logic node_in_range(input int idx, input int nodes);
      return (idx < nodes);
   endfunction

   // Flat bit position of edge i->j in the row-major adjacency vector.
   function automatic int adj_idx(input int i, input int j, input int nodes);
      return i * nodes + j;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wf_prio_enc.sv
// ============================================================================
//  Module      : wf_prio_enc
//  Description : NODES-input lowest-index priority encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wf_prio_enc #(
   parameter int NODES  = 64,
   parameter int NODE_W = $clog2(NODES)
) (
   input  logic [NODES-1:0]  i_req,
   output logic [NODE_W-1:0] o_idx
);

   // Scanning downwards lets the lowest set request overwrite any higher one.
   always_comb begin
      o_idx = '0;
      for (int i = NODES - 1; i >= 0; i--) begin
         if (i_req[i]) o_idx = NODE_W'(i);
      end
   end

endmodule

`default_nettype wire

// File: rtl/wavefront_router.sv
// ============================================================================
//  Module      : wavefront_router
//  Description : Breadth-first wavefront route search over an adjacency
//                matrix. Define WAVEFRONT_PRED_EN for the predecessor table.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wavefront_router
   import graph_pkg::*;
#(
   parameter int NODES  = 64,
   parameter int NODE_W = node_width(NODES)
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   start,
   input  logic [NODE_W-1:0]      start_node,
   input  logic [NODE_W-1:0]      goal_node,
   input  logic [NODES*NODES-1:0] adj,
   output logic                   busy,
   output logic                   done,
   output logic                   found,
   output logic [NODE_W-1:0]      hops,
   output logic [NODES-1:0]       visited
`ifdef WAVEFRONT_PRED_EN
   ,
   input  logic [NODE_W-1:0]      rd_node,
   output logic [NODE_W-1:0]      rd_pred
`endif
);

   localparam logic [NODES-1:0] c_ONE = {{(NODES-1){1'b0}}, 1'b1};

   wf_state_t              r_state;
   wf_state_t              w_next_state;
   logic [NODES*NODES-1:0] r_adj;
   logic [NODE_W-1:0]      r_goal;
   logic [NODES-1:0]       r_visited;
   logic [NODES-1:0]       r_frontier;
   logic [NODE_W-1:0]      r_hops;
   logic                   r_found;

   logic [NODES-1:0]       w_reach;
   logic [NODES-1:0]       w_new;
   logic [NODES-1:0]       w_src_onehot;
   logic                   w_start_ok;
   logic                   w_goal_hit;
   logic                   w_accept;

   assign w_accept     = (r_state == WF_IDLE) && start;
   assign w_start_ok   = node_in_range(int'(start_node), NODES) &&
                         node_in_range(int'(goal_node), NODES);
   assign w_src_onehot = c_ONE << start_node;

   always_comb begin
      w_reach = '0;
      for (int j = 0; j < NODES; j++) begin
         for (int i = 0; i < NODES; i++) begin
            w_reach[j] = w_reach[j] | (r_frontier[i] & r_adj[adj_idx(i, j, NODES)]);
         end
      end
   end

   assign w_new      = w_reach & ~r_visited;
   assign w_goal_hit = w_new[r_goal];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= WF_IDLE;
      else     r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         WF_IDLE: begin
            if (start) begin
               if (!w_start_ok || (start_node == goal_node)) w_next_state = WF_FINISH;
               else                                          w_next_state = WF_SEARCH;
            end
         end
         WF_SEARCH: begin
            if (w_goal_hit || (w_new == '0)) w_next_state = WF_FINISH;
         end
         WF_FINISH: w_next_state = WF_IDLE;
         default:   w_next_state = WF_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (r_state)
         WF_SEARCH: busy = 1'b1;
         WF_FINISH: done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_adj      <= '0;
         r_goal     <= '0;
         r_visited  <= '0;
         r_frontier <= '0;
         r_hops     <= '0;
         r_found    <= 1'b0;
      end else if (w_accept) begin
         r_adj  <= adj;
         r_goal <= goal_node;
         r_hops <= '0;
         if (w_start_ok) begin
            r_visited  <= w_src_onehot;
            r_frontier <= w_src_onehot;
            r_found    <= (start_node == goal_node);
         end else begin
            r_visited  <= '0;
            r_frontier <= '0;
            r_found    <= 1'b0;
         end
      end else if (r_state == WF_SEARCH) begin
         r_visited  <= r_visited | w_new;
         r_frontier <= w_new;
         if (w_new != '0) r_hops <= r_hops + 1'b1;
         r_found    <= w_goal_hit;
      end
   end

   assign found   = r_found;
   assign hops    = r_hops;
   assign visited = r_visited;

`ifdef WAVEFRONT_PRED_EN
   logic [NODE_W-1:0] r_pred    [NODES];
   logic [NODE_W-1:0] w_col_idx [NODES];

   // Each column encoder picks the lowest frontier node that reaches node j.
   for (genvar j = 0; j < NODES; j++) begin : g_col
      logic [NODES-1:0] w_col;
      always_comb begin
         w_col = '0;
         for (int i = 0; i < NODES; i++) begin
            w_col[i] = r_frontier[i] & r_adj[adj_idx(i, j, NODES)];
         end
      end
      wf_prio_enc #(
         .NODES  (NODES),
         .NODE_W (NODE_W)
      ) u_enc (
         .i_req (w_col),
         .o_idx (w_col_idx[j])
      );
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int j = 0; j < NODES; j++) r_pred[j] <= '0;
      end else if (w_accept) begin
         for (int j = 0; j < NODES; j++) r_pred[j] <= '0;
         if (w_start_ok) r_pred[start_node] <= start_node;
      end else if (r_state == WF_SEARCH) begin
         for (int j = 0; j < NODES; j++) begin
            if (w_new[j]) r_pred[j] <= w_col_idx[j];
         end
      end
   end

   assign rd_pred = node_in_range(int'(rd_node), NODES) ? r_pred[rd_node] : '0;
`endif

endmodule

`default_nettype wire
